// File: rtl/fir_decimator.sv
// Polyphase FIR lowpass decimator: circular sample RAM, one serial MAC pass
// over TAPS coefficients per DECIM accepted samples, one registered output.
module fir_decimator #(
  parameter int unsigned TAPS        = 86,
  parameter int unsigned DECIM       = 2,
  parameter int unsigned SAMPLE_SIZE = 16,
  parameter int unsigned COEFF_SIZE  = 16,
  parameter int unsigned SHIFT       = 3
) (
  input  logic                                      clk,
  input  logic                                      nrst,
  input  logic                                      din_valid,
  input  logic signed [SAMPLE_SIZE-1:0]             din,
  output logic                                      din_ready,
  output logic                                      coeff_en,
  output logic [$clog2(TAPS)-1:0]                   coeff_addr,
  input  logic signed [COEFF_SIZE-1:0]              coeff,
  output logic                                      dout_valid,
  output logic signed [SAMPLE_SIZE+COEFF_SIZE-1:0]  dout
);

  localparam int unsigned AW = $clog2(TAPS);
  localparam int unsigned FW = $clog2(TAPS + 1);
  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned OW = SAMPLE_SIZE + COEFF_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FLUSH, S_OUT} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic [FW-1:0]           fill_lat_q, fill_lat_d;
  logic [AW-1:0]           newest_q, newest_d;
  logic signed [OW-1:0]    acc_q, acc_d;
  logic signed [OW-1:0]    dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    din_ready_q, din_ready_d;
  logic                    coeff_en_q, coeff_en_d;
  logic [AW-1:0]           coeff_addr_q, coeff_addr_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    rd_mask_q, rd_mask_d;

  logic signed [SAMPLE_SIZE-1:0] ram [TAPS];
  logic signed [SAMPLE_SIZE-1:0] rd_data_q;

  logic                          accept;
  logic                          ram_we;
  logic [AW-1:0]                 ram_raddr;
  logic [FW-1:0]                 fill_inc;
  logic [AW-1:0]                 wr_ptr_inc;
  logic                          phase_last;
  logic signed [SAMPLE_SIZE-1:0] sample_op;
  logic signed [OW-1:0]          samp_x, coef_x, prod, mac_sum;

  assign din_ready  = din_ready_q;
  assign coeff_en   = coeff_en_q;
  assign coeff_addr = coeff_addr_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;

  // Shared datapath: handshake, pointer arithmetic and the masked product
  always_comb begin
    accept     = din_valid & din_ready_q;
    fill_inc   = (fill_q == FW'(TAPS)) ? fill_q : fill_q + FW'(1);
    wr_ptr_inc = (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + AW'(1);
    phase_last = (phase_q == PW'(DECIM - 1));
    ram_raddr  = (coeff_addr_q <= newest_q) ? newest_q - coeff_addr_q
                                            : newest_q + AW'(TAPS) - coeff_addr_q;
    sample_op  = rd_mask_q ? '0 : rd_data_q;
    samp_x     = OW'(sample_op);
    coef_x     = OW'(coeff);
    prod       = (samp_x * coef_x) >>> SHIFT;
    mac_sum    = acc_q + prod;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    phase_d      = phase_q;
    fill_d       = fill_q;
    fill_lat_d   = fill_lat_q;
    newest_d     = newest_q;
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    din_ready_d  = din_ready_q;
    coeff_en_d   = coeff_en_q;
    coeff_addr_d = coeff_addr_q;
    rd_vld_d     = 1'b0;
    rd_mask_d    = rd_mask_q;
    ram_we       = 1'b0;

    unique case (state_q)
      S_IDLE, S_OUT: begin
        state_d     = S_IDLE;
        din_ready_d = 1'b1;
        if (accept) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_inc;
          fill_d   = fill_inc;
          phase_d  = phase_last ? '0 : phase_q + PW'(1);
          if (phase_last) begin
            state_d      = S_MAC;
            acc_d        = '0;
            newest_d     = wr_ptr_q;
            fill_lat_d   = fill_inc;
            coeff_en_d   = 1'b1;
            coeff_addr_d = '0;
            din_ready_d  = 1'b0;
          end
        end
      end
      S_MAC: begin
        rd_vld_d  = 1'b1;
        // Taps beyond the samples seen since reset read as zero
        rd_mask_d = (32'(coeff_addr_q) >= 32'(fill_lat_q));
        if (rd_vld_q) acc_d = mac_sum;
        if (coeff_addr_q == AW'(TAPS - 1)) begin
          state_d      = S_FLUSH;
          coeff_en_d   = 1'b0;
          coeff_addr_d = '0;
        end else begin
          coeff_addr_d = coeff_addr_q + AW'(1);
        end
      end
      S_FLUSH: begin
        acc_d        = mac_sum;
        dout_d       = mac_sum;
        dout_valid_d = 1'b1;
        din_ready_d  = 1'b1;
        state_d      = S_OUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      phase_q      <= '0;
      fill_q       <= '0;
      fill_lat_q   <= '0;
      newest_q     <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b1;
      coeff_en_q   <= 1'b0;
      coeff_addr_q <= '0;
      rd_vld_q     <= 1'b0;
      rd_mask_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      phase_q      <= phase_d;
      fill_q       <= fill_d;
      fill_lat_q   <= fill_lat_d;
      newest_q     <= newest_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      din_ready_q  <= din_ready_d;
      coeff_en_q   <= coeff_en_d;
      coeff_addr_q <= coeff_addr_d;
      rd_vld_q     <= rd_vld_d;
      rd_mask_q    <= rd_mask_d;
    end
  end

  // Sample RAM: synchronous write on accept, one-cycle read aligned with coeff
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_ptr_q] <= din;
    rd_data_q <= ram[ram_raddr];
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed + random bench for fir_decimator against a queue-based convolution model.
module tb_fir_decimator;

  localparam int unsigned TAPS  = 86;
  localparam int unsigned DECIM = 2;
  localparam int unsigned SS    = 16;
  localparam int unsigned CS    = 16;
  localparam int unsigned SHIFT = 3;
  localparam int unsigned AW    = $clog2(TAPS);

  logic                 clk = 1'b0;
  logic                 nrst;
  logic                 din_valid;
  logic signed [SS-1:0] din;
  logic                 din_ready;
  logic                 coeff_en;
  logic [AW-1:0]        coeff_addr;
  logic signed [CS-1:0] coeff;
  logic                 dout_valid;
  logic signed [SS+CS-1:0] dout;

  fir_decimator #(.TAPS(TAPS), .DECIM(DECIM), .SAMPLE_SIZE(SS),
                  .COEFF_SIZE(CS), .SHIFT(SHIFT)) dut (
    .clk(clk), .nrst(nrst), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .coeff_en(coeff_en), .coeff_addr(coeff_addr),
    .coeff(coeff), .dout_valid(dout_valid), .dout(dout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic signed [CS-1:0] h [TAPS];
  logic signed [SS-1:0] xs [$];
  int                   exp_q [$];
  int                   got_q [$];
  int                   acc_cyc [$];
  int                   n_acc;

  always @(negedge clk) cyc <= cyc + 1;

  // Synchronous coefficient ROM
  always @(posedge clk) if (coeff_en) coeff <= h[coeff_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  // Output checker: every dout_valid pulse must match the next model output
  always @(negedge clk) begin
    if (nrst && dout_valid) begin
      if (exp_q.size() == 0) chk("unexpected_dout_valid", 32'd1, 32'd0);
      else begin
        chk("dout", dout, 32'(exp_q.pop_front()));
        got_q.push_back(int'(dout));
      end
    end
  end

  function automatic void model_accept(input logic signed [SS-1:0] x);
    int s;
    xs.push_front(x);
    if (xs.size() > TAPS) void'(xs.pop_back());
    n_acc++;
    acc_cyc.push_back(cyc);
    if (n_acc % DECIM == 0) begin
      s = 0;
      for (int k = 0; k < xs.size(); k++)
        s += (int'(xs[k]) * int'(h[k])) >>> SHIFT;
      exp_q.push_back(s);
    end
  endfunction

  function automatic void model_clear();
    xs.delete(); exp_q.delete(); got_q.delete(); acc_cyc.delete();
    n_acc = 0;
  endfunction

  // Called and returns at a falling edge
  task automatic send(input logic signed [SS-1:0] x);
    int guard = 0;
    din = x; din_valid = 1'b1;
    while (!din_ready && guard < 300) begin @(negedge clk); guard++; end
    if (guard >= 300) chk("send_timeout", 32'd1, 32'd0);
    else begin
      @(posedge clk);
      model_accept(x);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin @(negedge clk); guard++; end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; din_valid = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int low, n;
    nrst = 1'b0; din_valid = 1'b0; din = '0;
    for (int k = 0; k < TAPS; k++) h[k] = '0;
    n_acc = 0;
    repeat (3) @(negedge clk);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_coeff_en", 32'(coeff_en), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_din_ready", 32'(din_ready), 32'd1);
    chk("rst_dout", dout, 32'd0);
    chk("rst_coeff_addr", 32'(coeff_addr), 32'd0);

    // Impulse response
    for (int k = 0; k < TAPS; k++) h[k] = CS'(k + 1);
    send(16'sh0100);
    for (int i = 1; i < 2 * 44; i++) send('0);
    drain();
    chk("imp_count", 32'(got_q.size()), 32'd44);
    chk("imp_out0", 32'(got_q[0]), 32'd64);
    chk("imp_out1", 32'(got_q[1]), 32'd128);
    chk("imp_out2", 32'(got_q[2]), 32'd192);
    chk("imp_out42", 32'(got_q[42]), 32'd2752);
    chk("imp_out43", 32'(got_q[43]), 32'd0);

    // DC and fill ramp
    do_reset();
    for (int k = 0; k < TAPS; k++) h[k] = 16'sd100;
    for (int i = 0; i < 90; i++) send(16'sd1000);
    drain();
    chk("dc_out0", 32'(got_q[0]), 32'd25000);
    chk("dc_out1", 32'(got_q[1]), 32'd50000);
    chk("dc_out42", 32'(got_q[42]), 32'd1075000);
    chk("dc_out44", 32'(got_q[44]), 32'd1075000);

    // Handshake latency and throughput
    do_reset();
    for (int k = 0; k < TAPS; k++) h[k] = 16'sd1;
    send(16'sd7);
    send(16'sd9);
    low = 0; n = 1;
    while (!dout_valid && n < 300) begin
      if (!din_ready) low++;
      @(negedge clk); n++;
    end
    chk("hs_latency", 32'(n), 32'(TAPS + 2));
    chk("hs_ready_low", 32'(low), 32'(TAPS + 1));
    chk("hs_ready_at_out", 32'(din_ready), 32'd1);
    drain();
    acc_cyc.delete();
    for (int i = 0; i < 4; i++) send(16'(i * 3 - 5));
    chk("hs_pair_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    chk("hs_period0", 32'(acc_cyc[2] - acc_cyc[0]), 32'(TAPS + 3));
    chk("hs_period1", 32'(acc_cyc[3] - acc_cyc[1]), 32'(TAPS + 3));
    drain();

    // Arithmetic extremes
    do_reset();
    for (int k = 0; k < TAPS; k++) h[k] = '0;
    h[0] = -16'sd32768;
    send('0);
    send(-16'sd32768);
    drain();
    chk("ext_min_sq", 32'(got_q[0]), 32'd134217728);
    do_reset();
    h[0] = 16'sd1;
    send('0);
    send(-16'sd1);
    drain();
    chk("ext_neg_one", 32'(got_q[0]), 32'hFFFF_FFFF);

    // Random data across several pointer wraps, with idle gaps
    do_reset();
    for (int k = 0; k < TAPS; k++) h[k] = CS'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      send(SS'($urandom));
    end
    drain();
    chk("rand_count", 32'(got_q.size()), 32'd200);

    // Reset in the middle of a MAC pass
    do_reset();
    for (int k = 0; k < TAPS; k++) h[k] = CS'($urandom);
    for (int i = 0; i < 6; i++) send(SS'($urandom));
    drain();
    send(16'sd1234);
    send(-16'sd4321);
    repeat (39) @(negedge clk);
    nrst = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_dout", dout, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("mid_rel_din_ready", 32'(din_ready), 32'd1);
    repeat (100) @(negedge clk);
    chk("mid_no_output", 32'(got_q.size()), 32'd0);
    send(16'sd3000);
    send(-16'sd2000);
    drain();
    chk("mid_post_count", 32'(got_q.size()), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
